// File: rtl/lc3_inst_loader.sv
// Streams a program into the LC-3 instruction memory, holds the core in reset while loading,
// then releases it after a fixed settling window.
module lc3_inst_loader #(
  parameter logic [15:0] BASE_ADDR  = 16'h3000,
  parameter int          MAX_WORDS  = 256,
  parameter int          RESET_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic [15:0] din_inst,
  output logic        write_inst,
  output logic [15:0] addr_inst,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t      state, next_state;
  logic        accept;
  logic [16:0] count_inc;
  logic        at_max;
  logic [7:0]  hold_cnt;
  logic        hold_done;

  assign in_ready  = (state == LOAD);
  assign accept    = in_ready & in_valid;
  // 17-bit compare so MAX_WORDS = 65536 is reachable from a 16-bit count.
  assign count_inc = {1'b0, word_count} + 17'd1;
  assign at_max    = (count_inc == 17'(MAX_WORDS));
  assign hold_done = (hold_cnt == 8'(RESET_HOLD));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start)                          next_state = LOAD;
      LOAD: if (accept && (in_last || at_max))  next_state = HOLD;
      HOLD: if (hold_done)                      next_state = RUN;
      RUN:  if (start)                          next_state = LOAD;
      default:                                  next_state = IDLE;
    endcase
  end

  // NOTE: reset is synchronous; reset wins over any same-cycle acceptance so no write escapes.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_inst <= 1'b0;
      din_inst   <= 16'h0000;
      addr_inst  <= BASE_ADDR;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= 16'h0000;
      overflow   <= 1'b0;
      hold_cnt   <= 8'd0;
    end else begin
      write_inst <= accept;
      if (accept) begin
        din_inst   <= in_data;
        addr_inst  <= BASE_ADDR + word_count;
        word_count <= count_inc[15:0];
        if (at_max && !in_last) overflow <= 1'b1;
      end
      if ((state == IDLE || state == RUN) && start) begin
        word_count <= 16'h0000;
        overflow   <= 1'b0;
      end
      // The write-pulse cycle of the final word is the first counted hold cycle.
      if (state == LOAD && next_state == HOLD)  hold_cnt <= 8'd1;
      else if (state == HOLD && !hold_done)     hold_cnt <= hold_cnt + 8'd1;
      else if (state != HOLD)                   hold_cnt <= 8'd0;
      core_reset <= (next_state != RUN);
      busy       <= (next_state == LOAD) || (next_state == HOLD);
      done       <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_lc3_inst_loader.sv
// Directed bench: three loader instances (default, MAX_WORDS=4, BASE_ADDR=16'hFFFE) on one input stream.
module tb_lc3_inst_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [15:0] in_data;

  logic        a_ready, a_write, a_core_reset, a_busy, a_done, a_ovf;
  logic [15:0] a_din, a_addr, a_wc;
  logic        b_ready, b_write, b_core_reset, b_busy, b_done, b_ovf;
  logic [15:0] b_din, b_addr, b_wc;
  logic        c_ready, c_write, c_core_reset, c_busy, c_done, c_ovf;
  logic [15:0] c_din, c_addr, c_wc;

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  always #5 clk = ~clk;

  lc3_inst_loader u_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_data(in_data), .in_last(in_last), .din_inst(a_din), .write_inst(a_write),
    .addr_inst(a_addr), .core_reset(a_core_reset), .busy(a_busy), .done(a_done),
    .word_count(a_wc), .overflow(a_ovf)
  );

  lc3_inst_loader #(.MAX_WORDS(4)) u_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_data(in_data), .in_last(in_last), .din_inst(b_din), .write_inst(b_write),
    .addr_inst(b_addr), .core_reset(b_core_reset), .busy(b_busy), .done(b_done),
    .word_count(b_wc), .overflow(b_ovf)
  );

  lc3_inst_loader #(.BASE_ADDR(16'hFFFE)) u_c (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(c_ready),
    .in_data(in_data), .in_last(in_last), .din_inst(c_din), .write_inst(c_write),
    .addr_inst(c_addr), .core_reset(c_core_reset), .busy(c_busy), .done(c_done),
    .word_count(c_wc), .overflow(c_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] prog [3];
    logic        pat  [4];
    prog = '{16'h1021, 16'h5260, 16'hF025};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'h0000;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_write", a_write, 0);
    check("rst_din", a_din, 16'h0000);
    check("rst_addr", a_addr, 16'h3000);
    check("rst_addr_c", c_addr, 16'hFFFE);
    check("rst_core_reset", a_core_reset, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_wc", a_wc, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_ready", a_ready, 0);

    // Basic load of three words, in_valid held; instance c wraps its address
    start = 1'b1; tick(); start = 1'b0;
    check("load_ready", a_ready, 1);
    check("load_busy", a_busy, 1);
    check("load_core_reset", a_core_reset, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = prog[i];
      in_last = (i == 2);
      tick();
      check("basic_write", a_write, 1);
      check("basic_din", a_din, prog[i]);
      check("basic_addr", a_addr, 16'h3000 + 16'(i));
      check("basic_wc", a_wc, i + 1);
      check("wrap_addr", c_addr, 16'(16'hFFFE + 16'(i)));
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("hold_ready", a_ready, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("hold_write", a_write, 0);
      check("hold_core_reset", a_core_reset, 1);
    end
    tick();
    check("run_core_reset", a_core_reset, 0);
    check("run_done", a_done, 1);
    check("run_busy", a_busy, 0);
    check("run_ovf", a_ovf, 0);
    check("run_wc", a_wc, 3);
    check("run_done_c", c_done, 1);

    // in_valid ignored in RUN
    in_valid = 1'b1; in_data = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    check("run_ignore_write", a_write, 0);
    check("run_ignore_wc", a_wc, 3);

    // Reload from RUN, then back-pressure gaps with a stray start during LOAD
    start = 1'b1; tick(); start = 1'b0;
    check("reload_core_reset", a_core_reset, 1);
    check("reload_done", a_done, 0);
    check("reload_wc", a_wc, 0);
    check("reload_ready", a_ready, 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[i];
      in_data  = (i == 0) ? 16'hAAAA : ((i == 3) ? 16'hBBBB : 16'h5555);
      in_last  = (i == 3);
      start    = (i == 1);
      tick();
      pulses += int'(a_write);
      check("bp_write", a_write, pat[i]);
      check("bp_wc", a_wc, (i < 3) ? 1 : 2);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("bp_pulses", pulses, 2);
    check("bp_addr", a_addr, 16'h3001);
    check("bp_din", a_din, 16'hBBBB);
    for (int k = 0; k < 4; k++) tick();
    check("bp_run", a_done, 1);

    // Overflow on the MAX_WORDS=4 instance: six words offered, no in_last
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_last = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'h0100 + 16'(i);
      tick();
      pulses += int'(b_write);
      if (i == 3) begin
        check("ovf_write4", b_write, 1);
        check("ovf_wc", b_wc, 4);
        check("ovf_flag", b_ovf, 1);
        check("ovf_ready", b_ready, 0);
        check("ovf_addr", b_addr, 16'h3003);
      end
    end
    in_valid = 1'b0;
    check("ovf_pulses", pulses, 4);
    check("ovf_wc_default", a_wc, 6);
    check("ovf_flag_default", a_ovf, 0);
    tick();
    check("ovf_hold_core_reset", b_core_reset, 1);
    tick();
    check("ovf_run_done", b_done, 1);
    check("ovf_run_core_reset", b_core_reset, 0);
    check("ovf_sticky", b_ovf, 1);

    // Load without further words stays in LOAD indefinitely
    for (int k = 0; k < 5; k++) tick();
    check("stall_busy", a_busy, 1);
    check("stall_core_reset", a_core_reset, 1);
    check("stall_ready", a_ready, 1);

    // Reset on the cycle of the second acceptance
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111;
    tick();
    check("mid_first_write", a_write, 1);
    in_data = 16'h2222; reset = 1'b1; start = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_write", a_write, 0);
    check("mid_din", a_din, 16'h0000);
    check("mid_addr", a_addr, 16'h3000);
    check("mid_wc", a_wc, 0);
    check("mid_core_reset", a_core_reset, 1);
    check("mid_busy", a_busy, 0);
    check("mid_done", a_done, 0);
    check("mid_ovf", a_ovf, 0);
    tick();
    reset = 1'b0; start = 1'b0;
    check("prio_busy", a_busy, 0);
    check("prio_ready", a_ready, 0);
    check("prio_write", a_write, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_inst_loader.md
LC3_INST_LOADER -- requirements
Module: lc3_inst_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h3000, first instruction-memory address written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256, maximum words per load (range 1..65536).
REQ-003 The block SHALL have parameter RESET_HOLD, default 4, cycles core_reset stays high after the final write (range 1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have these other ports:
- start  input  1  begin a program load.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  16  instruction word.
- in_last  input  1  marks the final word of the program.
- din_inst  output  16  to Top instruction-memory data.
- write_inst  output  1  to Top instruction-memory write strobe.
- addr_inst  output  16  to Top instruction-memory address.
- core_reset  output  1  reset to Top core; high while loading.
- busy  output  1  high in LOAD or HOLD.
- done  output  1  high in RUN.
- word_count  output  16  words written in the current load.
- overflow  output  1  sticky; MAX_WORDS reached without in_last.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, HOLD, RUN, all outputs registered except in_ready.
REQ-007 In IDLE, start=1 SHALL move to LOAD next cycle, clear word_count and overflow, and keep core_reset=1.
REQ-008 in_ready SHALL equal (state==LOAD); words are accepted only on cycles with in_valid=1 and in_ready=1.
REQ-009 On each accepted word, the next cycle SHALL have write_inst=1 for exactly one cycle, din_inst=in_data, addr_inst=BASE_ADDR+word_count (mod 2^16), and word_count incremented.
REQ-010 write_inst SHALL be 0 in every cycle not following an acceptance; din_inst/addr_inst hold their last values.
REQ-011 Address arithmetic SHALL be 16-bit and wrap 16'hFFFF -> 16'h0000 with no error.
REQ-012 An accepted word with in_last=1 SHALL move LOAD -> HOLD.
REQ-013 An accepted word that makes word_count==MAX_WORDS with in_last=0 SHALL move LOAD -> HOLD and set overflow=1.
REQ-014 In HOLD, core_reset SHALL stay 1 for exactly RESET_HOLD cycles counted from the cycle write_inst pulses for the final word, then the FSM SHALL enter RUN.
REQ-015 In RUN, core_reset SHALL be 0 and done=1; in_valid SHALL be ignored.
REQ-016 start=1 in RUN SHALL return to LOAD next cycle with core_reset=1, done=0, word_count=0, overflow=0.
REQ-017 start SHALL be ignored in LOAD and HOLD.
REQ-018 A start=1 with no subsequent words SHALL keep the FSM in LOAD indefinitely with core_reset=1.
REQ-019 busy SHALL be 1 exactly when state is LOAD or HOLD.

Reset
REQ-020 reset=1 SHALL, at the next clock edge and regardless of state, force IDLE, write_inst=0, din_inst=0, addr_inst=BASE_ADDR, core_reset=1, busy=0, done=0, word_count=0, overflow=0, hold counter=0.
REQ-021 reset asserted mid-LOAD SHALL suppress any write_inst pulse pending from the same cycle's acceptance.
REQ-022 reset SHALL take priority over start and in_valid on the same cycle.

Verification
REQ-023 Basic load: start, then 3 words 16'h1021,16'h5260,16'hF025 (last on third) with in_valid held -> write_inst pulses at 16'h3000/3001/3002 with those data, word_count=3, core_reset falls 4 cycles after third pulse, done=1, overflow=0.
REQ-024 Back-pressure gaps: in_valid toggled 1,0,0,1 over two words -> exactly 2 write pulses, no duplicate writes, addresses contiguous.
REQ-025 Overflow: MAX_WORDS=4, 6 words offered without in_last -> 4 writes, overflow=1, in_ready=0 after the 4th acceptance, RUN entered.
REQ-026 Wrap: BASE_ADDR=16'hFFFE, 3 words -> addresses 16'hFFFE, 16'hFFFF, 16'h0000.
REQ-027 Reset mid-load: reset on the cycle of the 2nd acceptance -> no 2nd write pulse, all outputs at reset values, core_reset=1.
REQ-028 Reload: start in RUN -> core_reset=1 next cycle, word_count=0, new program written from BASE_ADDR.
